// File: rtl/reg_access_arbiter_if.sv
// Bus bundle between two requesters, the reg_access_arbiter and the shared
// register bank. The arbiter connects through the slave modport; the
// requester/bank side (e.g. a testbench) uses the master modport.
interface reg_access_arbiter_if #(
   parameter int NREG = 12,
   parameter int DW   = 16
);
   logic            a_req;
   logic            a_we;
   logic [3:0]      a_addr;
   logic [DW-1:0]   a_wdata;
   logic            a_gnt;
   logic            a_done;
   logic [DW-1:0]   a_rdata;
   logic            a_err;

   logic            b_req;
   logic            b_we;
   logic [3:0]      b_addr;
   logic [DW-1:0]   b_wdata;
   logic            b_gnt;
   logic            b_done;
   logic [DW-1:0]   b_rdata;
   logic            b_err;

   logic [NREG-1:0] read;
   logic [NREG-1:0] write;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  rdata,
      output a_gnt, a_done, a_rdata, a_err,
      output b_gnt, b_done, b_rdata, b_err,
      output read, write, wdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output rdata,
      input  a_gnt, a_done, a_rdata, a_err,
      input  b_gnt, b_done, b_rdata, b_err,
      input  read, write, wdata
   );
endinterface

// File: rtl/reg_access_arbiter.sv
// Two-requester arbiter in front of a shared register bank.
// Each access takes three cycles: IDLE (grant + latch), ACCESS (one-hot
// strobe to the bank), RESP (done pulse, read data returned to the owner).
// Ties are resolved round-robin by default; defining REG_ARB_FIXED_PRIO_EN
// switches to fixed priority where requester A always wins a tie.
module reg_access_arbiter #(
   parameter int NREG = 12,
   parameter int DW   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   reg_access_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_d;

   logic            owner_b;
   logic            we_q;
   logic [3:0]      addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   a_rdata_q;
   logic [DW-1:0]   b_rdata_q;
`ifndef REG_ARB_FIXED_PRIO_EN
   logic            last_b;
`endif

   logic            any_req;
   logic            pick_b;
   logic            addr_err;
   logic            in_idle;
   logic            in_resp;
   logic            a_done_c;
   logic            b_done_c;
   logic            a_read_done;
   logic            b_read_done;
   logic [NREG-1:0] read_c;
   logic [NREG-1:0] write_c;

   assign any_req  = bus.a_req | bus.b_req;
   assign in_idle  = (state == IDLE);
   assign in_resp  = (state == RESP);
   assign addr_err = ({1'b0, addr_q} >= 5'(NREG));

`ifdef REG_ARB_FIXED_PRIO_EN
   assign pick_b = bus.b_req & ~bus.a_req;
`else
   assign pick_b = bus.b_req & (~bus.a_req | ~last_b);
`endif

   // State register; reset aborts any in-flight access immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic: one state per cycle, a request only matters in IDLE.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latching on grant, tie pointer update and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_b   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 4'd0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
         last_b    <= 1'b1;
`endif
      end else begin
         if (in_idle && any_req) begin
            owner_b <= pick_b;
            we_q    <= pick_b ? bus.b_we    : bus.a_we;
            addr_q  <= pick_b ? bus.b_addr  : bus.a_addr;
            wdata_q <= pick_b ? bus.b_wdata : bus.a_wdata;
`ifndef REG_ARB_FIXED_PRIO_EN
            last_b  <= pick_b;
`endif
         end
         if (a_read_done) a_rdata_q <= bus.rdata;
         if (b_read_done) b_rdata_q <= bus.rdata;
      end
   end

   // One-hot bank strobes, only during ACCESS and only for a valid index.
   always_comb begin
      read_c  = '0;
      write_c = '0;
      if (state == ACCESS && !addr_err) begin
         for (int i = 0; i < NREG; i++) begin
            if (addr_q == 4'(i)) begin
               if (we_q) write_c[i] = 1'b1;
               else      read_c[i]  = 1'b1;
            end
         end
      end
   end

   assign a_done_c    = in_resp & ~owner_b;
   assign b_done_c    = in_resp &  owner_b;
   assign a_read_done = a_done_c & ~we_q & ~addr_err;
   assign b_read_done = b_done_c & ~we_q & ~addr_err;

   assign bus.a_gnt   = in_idle & ~rst & bus.a_req & ~pick_b;
   assign bus.b_gnt   = in_idle & ~rst & pick_b;
   assign bus.a_done  = a_done_c;
   assign bus.b_done  = b_done_c;
   assign bus.a_err   = a_done_c & addr_err;
   assign bus.b_err   = b_done_c & addr_err;
   assign bus.a_rdata = a_read_done ? bus.rdata : a_rdata_q;
   assign bus.b_rdata = b_read_done ? bus.rdata : b_rdata_q;
   assign bus.read    = read_c;
   assign bus.write   = write_c;
   assign bus.wdata   = wdata_q;

endmodule
